mul_ternary_ctrl: RTL

Sequencer for the ternary polynomial multiplier. It computes c = a·s mod (x^N − 1), or mod (x^N + 1) when negacyclic, using one `mau` instance as its only arithmetic resource. a is a dense coefficient vector mod Q, and s is a ternary vector. All three vectors live in external synchronous RAMs. The block owns the read/write sequencing, the zero-row skipping and the start/done handshake toward the accelerator's register interface.

---
 rtl/mul_ternary_ctrl.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/mul_ternary_ctrl.sv
// +-----------------------------------------------------------------------+
// | mul_ternary_ctrl : sequencer for c = a*s mod (x^N -/+ 1), one mau     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module mau #(
  parameter int PARAM_LOG_Q = 8,
  parameter int PARAM_Q     = 251
) (
  input  logic [PARAM_LOG_Q-1:0] in_1,
  input  logic [PARAM_LOG_Q-1:0] in_2,
  input  logic [1:0]             in_sel,
  output logic [PARAM_LOG_Q-1:0] out_1
);
  localparam logic [PARAM_LOG_Q:0] c_Q = (PARAM_LOG_Q+1)'(PARAM_Q);

  logic [PARAM_LOG_Q:0] w_sum;
  logic [PARAM_LOG_Q:0] w_diff;

  assign w_sum  = {1'b0, in_2} + {1'b0, in_1};
  assign w_diff = {1'b0, in_2} - {1'b0, in_1};

  // 01: in_2 + in_1, 11: in_2 - in_1, both mod Q; anything else passes in_2
  always_comb begin
    out_1 = in_2;
    case (in_sel)
      2'b01:   out_1 = (w_sum >= c_Q) ? PARAM_LOG_Q'(w_sum - c_Q) : w_sum[PARAM_LOG_Q-1:0];
      2'b11:   out_1 = (in_2 < in_1) ? PARAM_LOG_Q'(w_diff + c_Q) : w_diff[PARAM_LOG_Q-1:0];
      default: out_1 = in_2;
    endcase
  end
endmodule

module mul_ternary_ctrl #(
  parameter int PARAM_LOG_Q = 8,
  parameter int PARAM_Q     = 251,
  parameter int PARAM_N     = 8,
  parameter int PARAM_LOG_N = 3,
  parameter int NEGACYCLIC  = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [PARAM_LOG_N-1:0] s_addr,
  input  logic [1:0]             s_rdata,
  output logic [PARAM_LOG_N-1:0] a_addr,
  input  logic [PARAM_LOG_Q-1:0] a_rdata,
  output logic [PARAM_LOG_N-1:0] c_raddr,
  input  logic [PARAM_LOG_Q-1:0] c_rdata,
  output logic [PARAM_LOG_N-1:0] c_waddr,
  output logic [PARAM_LOG_Q-1:0] c_wdata,
  output logic                   c_we
);
  localparam logic [PARAM_LOG_N-1:0] c_LAST = PARAM_LOG_N'(PARAM_N - 1);
  localparam logic [PARAM_LOG_N-1:0] c_ONE  = PARAM_LOG_N'(1);
  localparam logic [PARAM_LOG_N:0]   c_NW   = (PARAM_LOG_N+1)'(PARAM_N);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CLEAR, ST_S_REQ, ST_S_WAIT, ST_ROW, ST_DRAIN, ST_DONE
  } state_t;

  state_t                 r_state;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_c_we;
  logic                   r_wstage;
  logic [PARAM_LOG_N-1:0] r_s_addr;
  logic [PARAM_LOG_N-1:0] r_a_addr;
  logic [PARAM_LOG_N-1:0] r_c_raddr;
  logic [PARAM_LOG_N-1:0] r_c_waddr;
  logic [PARAM_LOG_N-1:0] r_i;
  logic [PARAM_LOG_N-1:0] r_j;
  logic [1:0]             r_s_cur;
  logic [1:0]             r_sel;

  logic [PARAM_LOG_N:0]   w_k_sum;
  logic [PARAM_LOG_N-1:0] w_k_nxt;
  logic                   w_wrap;
  logic [1:0]             w_sel;
  logic                   w_s_nz;
  logic [PARAM_LOG_Q-1:0] w_mau_out;

  // Read address for index j+1, computed while j is being issued
  assign w_k_sum = {1'b0, r_i} + {1'b0, r_j} + (PARAM_LOG_N+1)'(1);
  assign w_k_nxt = (w_k_sum >= c_NW) ? PARAM_LOG_N'(w_k_sum - c_NW) : w_k_sum[PARAM_LOG_N-1:0];

  // k = (i+j) mod N wrapped exactly when it fell below i
  assign w_wrap = (r_c_raddr < r_i);
  assign w_s_nz = (s_rdata == 2'b01) || (s_rdata == 2'b11);

  always_comb begin
    w_sel = (r_s_cur == 2'b01) ? 2'b01 : 2'b11;
    if ((NEGACYCLIC != 0) && w_wrap) begin
      w_sel = w_sel ^ 2'b10;
    end
  end

  mau #(
    .PARAM_LOG_Q(PARAM_LOG_Q),
    .PARAM_Q    (PARAM_Q)
  ) u_mau (
    .in_1  (a_rdata),
    .in_2  (c_rdata),
    .in_sel(r_sel),
    .out_1 (w_mau_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_c_we    <= 1'b0;
      r_wstage  <= 1'b0;
      r_s_addr  <= '0;
      r_a_addr  <= '0;
      r_c_raddr <= '0;
      r_c_waddr <= '0;
      r_i       <= '0;
      r_j       <= '0;
      r_s_cur   <= 2'b00;
      r_sel     <= 2'b00;
    end else begin
      r_done   <= 1'b0;
      r_c_we   <= 1'b0;
      r_wstage <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state   <= ST_CLEAR;
            r_busy    <= 1'b1;
            r_j       <= '0;
            r_c_we    <= 1'b1;
            r_c_waddr <= '0;
          end
        end
        ST_CLEAR: begin
          if (r_j == c_LAST) begin
            r_i      <= '0;
            r_s_addr <= '0;
            r_state  <= ST_S_REQ;
          end else begin
            r_j       <= r_j + c_ONE;
            r_c_we    <= 1'b1;
            r_c_waddr <= r_j + c_ONE;
          end
        end
        ST_S_REQ: begin
          r_state <= ST_S_WAIT;
        end
        ST_S_WAIT: begin
          r_s_cur <= s_rdata;
          if (w_s_nz) begin
            r_j       <= '0;
            r_a_addr  <= '0;
            r_c_raddr <= r_i;
            r_state   <= ST_ROW;
          end else begin
            r_i <= r_i + c_ONE;
            if (r_i == c_LAST) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_s_addr <= r_i + c_ONE;
              r_state  <= ST_S_REQ;
            end
          end
        end
        ST_ROW: begin
          // Pipeline capture: this read index becomes next cycle's write index
          r_c_waddr <= r_c_raddr;
          r_sel     <= w_sel;
          r_c_we    <= 1'b1;
          r_wstage  <= 1'b1;
          r_c_raddr <= w_k_nxt;
          if (r_j == c_LAST) begin
            r_state <= ST_DRAIN;
          end else begin
            r_j      <= r_j + c_ONE;
            r_a_addr <= r_j + c_ONE;
          end
        end
        ST_DRAIN: begin
          r_i <= r_i + c_ONE;
          if (r_i == c_LAST) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_s_addr <= r_i + c_ONE;
            r_state  <= ST_S_REQ;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign s_addr  = r_s_addr;
  assign a_addr  = r_a_addr;
  assign c_raddr = r_c_raddr;
  assign c_waddr = r_c_waddr;
  assign c_we    = r_c_we;
  assign c_wdata = r_wstage ? w_mau_out : '0;

endmodule

`default_nettype wire
